// File: rtl/stw_pkg.sv
// Shared types and the fixed MAC test-vector table for the PE self-test controller.
package stw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_GUARD,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } stw_state_e;

    localparam int STW_NUM_VECTORS = 4;
    localparam int STW_IDX_W       = $clog2(STW_NUM_VECTORS);

    typedef struct packed {
        logic [15:0] op1;
        logic [15:0] op2;
        logic [15:0] add;
        logic [15:0] expected;
    } stw_vec_t;

    // expected = op1*op2 + add, truncated to 16 bits
    function automatic stw_vec_t stw_vector(input logic [STW_IDX_W-1:0] idx);
        stw_vec_t v;
        case (idx)
            2'd0:    v = {16'd3,     16'd5,     16'd7,     16'd22};
            2'd1:    v = {16'hFFFF,  16'h0001,  16'h0001,  16'h0000};
            2'd2:    v = {16'h00FF,  16'h0100,  16'h0000,  16'hFF00};
            default: v = {16'h8000,  16'h0002,  16'h1234,  16'h1234};
        endcase
        return v;
    endfunction

endpackage

// File: rtl/stw_vector_rom.sv
// Combinational index-to-vector lookup; the top registers the result on entry to LOAD.
module stw_vector_rom
    import stw_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  logic [STW_IDX_W-1:0] idx_i,
    output logic [WORD_SIZE-1:0] op1_o,
    output logic [WORD_SIZE-1:0] op2_o,
    output logic [WORD_SIZE-1:0] add_o,
    output logic [WORD_SIZE-1:0] expected_o
);

    stw_vec_t vec;

    assign vec        = stw_vector(idx_i);
    assign op1_o      = WORD_SIZE'(vec.op1);
    assign op2_o      = WORD_SIZE'(vec.op2);
    assign add_o      = WORD_SIZE'(vec.add);
    assign expected_o = WORD_SIZE'(vec.expected);

endmodule

// File: rtl/stw_test_controller.sv
// Array-level self-test initiator: broadcasts each test vector to all PEs, waits for
// completion (with guard and timeout) and folds per-PE pass/fail into a sticky fault map.
module stw_test_controller
    import stw_pkg::*;
#(
    parameter int WORD_SIZE      = 16,
    parameter int NUM_PE         = 16,
    parameter int GUARD_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 test_req,
    output logic                 test_busy,
    output logic                 test_done,
    output logic [NUM_PE-1:0]    fault_map,
    output logic                 STW_test_load_en,
    output logic [WORD_SIZE-1:0] STW_mult_op1,
    output logic [WORD_SIZE-1:0] STW_mult_op2,
    output logic [WORD_SIZE-1:0] STW_add_op,
    output logic [WORD_SIZE-1:0] STW_expected,
    output logic                 STW_start,
    input  logic [NUM_PE-1:0]    STW_complete,
    input  logic [NUM_PE-1:0]    STW_result_out
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]     GUARD_END   = CNT_W'(GUARD_CYCLES);
    localparam logic [CNT_W-1:0]     TIMEOUT_END = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [STW_IDX_W-1:0] LAST_IDX    = STW_IDX_W'(STW_NUM_VECTORS - 1);

    stw_state_e             state_q;
    logic [STW_IDX_W-1:0]   idx_q;
    logic [STW_IDX_W-1:0]   rom_idx_d;
    logic [CNT_W-1:0]       cnt_q;
    logic                   busy_q, done_q, load_q, start_q;
    logic [NUM_PE-1:0]      map_q;
    logic [WORD_SIZE-1:0]   op1_q, op2_q, add_q, exp_q;
    logic [WORD_SIZE-1:0]   rom_op1, rom_op2, rom_add, rom_exp;

    // The ROM is addressed by the index of the vector about to be loaded.
    assign rom_idx_d = (state_q == ST_SAMPLE) ? idx_q + 1'b1 : '0;

    stw_vector_rom #(.WORD_SIZE(WORD_SIZE)) u_rom (
        .idx_i      (rom_idx_d),
        .op1_o      (rom_op1),
        .op2_o      (rom_op2),
        .add_o      (rom_add),
        .expected_o (rom_exp)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            load_q  <= 1'b0;
            start_q <= 1'b0;
            map_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            add_q   <= '0;
            exp_q   <= '0;
        end else begin
            load_q  <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: if (test_req) begin
                    state_q <= ST_LOAD;
                    busy_q  <= 1'b1;
                    load_q  <= 1'b1;
                    map_q   <= '0;
                    idx_q   <= '0;
                    {op1_q, op2_q, add_q, exp_q} <= {rom_op1, rom_op2, rom_add, rom_exp};
                end
                ST_LOAD: begin
                    state_q <= ST_START;
                    start_q <= 1'b1;
                end
                ST_START: begin
                    state_q <= ST_GUARD;
                    cnt_q   <= CNT_W'(1);
                end
                // Complete may still be high from the previous vector; don't look yet.
                ST_GUARD: begin
                    if (cnt_q == GUARD_END) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= CNT_W'(1);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if ((&STW_complete) || (cnt_q == TIMEOUT_END))
                        state_q <= ST_SAMPLE;
                    else
                        cnt_q <= cnt_q + 1'b1;
                end
                ST_SAMPLE: begin
                    map_q <= map_q | ~(STW_complete & STW_result_out);
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_LOAD;
                        load_q  <= 1'b1;
                        {op1_q, op2_q, add_q, exp_q} <= {rom_op1, rom_op2, rom_add, rom_exp};
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign test_busy        = busy_q;
    assign test_done        = done_q;
    assign fault_map        = map_q;
    assign STW_test_load_en = load_q;
    assign STW_start        = start_q;
    assign STW_mult_op1     = op1_q;
    assign STW_mult_op2     = op2_q;
    assign STW_add_op       = add_q;
    assign STW_expected     = exp_q;

endmodule

// File: tb/tb_stw_test_controller.sv
// Directed bench for stw_test_controller with a small behavioural PE-array model.
module tb_stw_test_controller;

    localparam int WS = 16;
    localparam int NP = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          test_req = 1'b0;
    logic          test_busy, test_done, STW_test_load_en, STW_start;
    logic [NP-1:0] fault_map, STW_complete, STW_result_out;
    logic [WS-1:0] STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected;

    stw_test_controller #(
        .WORD_SIZE(WS), .NUM_PE(NP), .GUARD_CYCLES(2), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst(rst), .test_req(test_req),
        .test_busy(test_busy), .test_done(test_done), .fault_map(fault_map),
        .STW_test_load_en(STW_test_load_en),
        .STW_mult_op1(STW_mult_op1), .STW_mult_op2(STW_mult_op2),
        .STW_add_op(STW_add_op), .STW_expected(STW_expected),
        .STW_start(STW_start),
        .STW_complete(STW_complete), .STW_result_out(STW_result_out)
    );

    always #5 clk = ~clk;

    // PE model: completes 3 cycles after start. Modes inject faults or stale completes.
    logic stale_mode = 1'b0, never0 = 1'b0, bad5 = 1'b0;
    int   age;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       age <= 0;
        else if (STW_start)             age <= 1;
        else if (age > 0 && age < 100)  age <= age + 1;
    end

    always_comb begin
        STW_complete   = '0;
        STW_result_out = '0;
        for (int i = 0; i < NP; i++) begin
            STW_result_out[i] = (age >= 3) && !(bad5 && i == 5 && STW_mult_op1 == 16'hFFFF);
            STW_complete[i]   = stale_mode ? 1'b1 : ((age >= 3) && !(never0 && i == 0));
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0]   cap [4];
    logic [NP-1:0] map_first, map_v3;

    localparam logic [63:0] V0 = 64'h0003_0005_0007_0016;
    localparam logic [63:0] V1 = 64'hFFFF_0001_0001_0000;
    localparam logic [63:0] V2 = 64'h00FF_0100_0000_FF00;
    localparam logic [63:0] V3 = 64'h8000_0002_1234_1234;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse test_req, then follow the run until test_done (cyc=1 is the first LOAD cycle).
    task automatic run(input int limit, input int pulse_at, output int cyc, output int loads);
        test_req = 1'b1;
        @(negedge clk);
        test_req = 1'b0;
        cyc = 1;
        loads = 0;
        while (1) begin
            if (STW_test_load_en === 1'b1) begin
                if (loads < 4) cap[loads] = {STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected};
                if (loads == 0) map_first = fault_map;
                if (STW_mult_op1 == 16'h8000) map_v3 = fault_map;
                loads++;
            end
            if (test_done === 1'b1 || cyc >= limit) break;
            test_req = (cyc == pulse_at);
            @(negedge clk);
            cyc++;
        end
        test_req = 1'b0;
    endtask

    initial begin
        int cyc, loads, extra;

        #1;
        chk("reset_ctrl", 64'({test_busy, test_done, STW_test_load_en, STW_start, fault_map}), 64'd0);
        chk("reset_ops", {STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Healthy array
        run(400, -1, cyc, loads);
        chk("healthy_cycles", 64'(cyc), 64'd25);
        chk("healthy_loads", 64'(loads), 64'd4);
        chk("healthy_map", 64'(fault_map), 64'd0);
        chk("vec0", cap[0], V0);
        chk("vec1", cap[1], V1);
        chk("vec2", cap[2], V2);
        chk("vec3", cap[3], V3);
        @(negedge clk);
        chk("busy_drop", 64'({test_busy, test_done}), 64'd0);
        @(negedge clk);

        // PE 5 fails V1 only; fault bit must persist through V2/V3
        bad5 = 1'b1;
        run(400, -1, cyc, loads);
        chk("pe5_cycles", 64'(cyc), 64'd25);
        chk("pe5_map_at_v3", 64'(map_v3), 64'h0020);
        chk("pe5_map", 64'(fault_map), 64'h0020);

        // test_req held high out of DONE: new run starts and clears the map first
        bad5 = 1'b0;
        test_req = 1'b1;
        @(negedge clk);
        chk("idle_map_hold", 64'({test_busy, fault_map}), 64'h0020);
        run(400, -1, cyc, loads);
        chk("rerun_map_first", 64'(map_first), 64'd0);
        chk("rerun_cycles", 64'(cyc), 64'd25);
        chk("rerun_map", 64'(fault_map), 64'd0);
        @(negedge clk);

        // PE 0 never completes; test_req pulsed mid-WAIT must be ignored
        never0 = 1'b1;
        run(600, 10, cyc, loads);
        chk("timeout_cycles", 64'(cyc), 64'd277);
        chk("timeout_loads", 64'(loads), 64'd4);
        chk("timeout_map", 64'(fault_map), 64'h0001);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (STW_test_load_en === 1'b1) extra++;
        end
        chk("no_second_run", 64'(extra), 64'd0);

        // Stale complete=1 with result=0 from reset
        never0 = 1'b0;
        stale_mode = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run(400, -1, cyc, loads);
        chk("stale_cycles", 64'(cyc), 64'd25);
        chk("stale_map", 64'(fault_map), 64'd0);
        stale_mode = 1'b0;
        @(negedge clk);

        // Reset during WAIT of V2
        never0 = 1'b1;
        test_req = 1'b1;
        @(negedge clk);
        test_req = 1'b0;
        repeat (148) @(negedge clk);
        chk("midrun_state", {16'(STW_mult_op1), 47'd0, test_busy}, {16'h00FF, 47'd0, 1'b1});
        chk("midrun_map", 64'(fault_map), 64'h0001);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_ctrl", 64'({test_busy, test_done, STW_test_load_en, STW_start, fault_map}), 64'd0);
        chk("async_rst_ops", {STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        never0 = 1'b0;
        @(negedge clk);
        run(400, -1, cyc, loads);
        chk("restart_vec0", cap[0], V0);
        chk("restart_cycles", 64'(cyc), 64'd25);
        chk("restart_map", 64'(fault_map), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stw_test_controller.md
# stw_test_controller

Array-level initiator for the PE self-test-word (STW) port. On request, it broadcasts a fixed sequence of MAC test vectors to every `pe_stw` in the array. For each vector it pulses start, waits for all PEs to report complete, and folds each PE's pass/fail into a sticky fault map. It sits beside the matmul FSM and holds the array off while a self-test runs; PE bypass itself is driven locally by each PE's `STW_result_out`.

## Interface
- `WORD_SIZE`, 16, operand/result width (matches `pe_stw`)
- `NUM_PE`, 16, number of PEs served (array flattened, index = row*cols+col)
- `GUARD_CYCLES`, 2, cycles after `STW_start` before `STW_complete` is trusted
- `TIMEOUT_CYCLES`, 64, max WAIT cycles per vector before missing PEs are declared faulty

Ports:
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: asynchronous, active-low reset
- `test_req` in 1: start a full self-test run (sampled in IDLE only)
- `test_busy` out 1: high from the first LOAD through DONE inclusive; matmul FSM must hold while high
- `test_done` out 1: one-cycle pulse when `fault_map` is final
- `fault_map` out NUM_PE: bit i = 1 means PE i failed or timed out on any vector of the last run
- `STW_test_load_en` out 1: one-cycle load strobe, broadcast
- `STW_mult_op1`, `STW_mult_op2`, `STW_add_op`, `STW_expected` out WORD_SIZE each: current vector, broadcast, stable from LOAD until next LOAD
- `STW_start` out 1: one-cycle start pulse, broadcast
- `STW_complete` in NUM_PE: per-PE complete
- `STW_result_out` in NUM_PE: per-PE result (1 = pass), valid while complete is high

## Operation
- States: IDLE → LOAD → START → GUARD → WAIT → SAMPLE → (LOAD for next vector | DONE) → IDLE.
- IDLE: if `test_req`=1, go to LOAD. Clear `fault_map` to 0 and vector index to 0 on this transition.
- LOAD: drive vector[idx] on the op buses and assert `STW_test_load_en` for exactly this cycle.
- START: assert `STW_start` for exactly this cycle.
- GUARD: count `GUARD_CYCLES` cycles and ignore `STW_complete`, since stale complete from a prior test must not be sampled.
- WAIT: leave when `&STW_complete`=1 or the timeout counter reaches `TIMEOUT_CYCLES`.
- SAMPLE (one cycle): `fault_map <= fault_map | ~(STW_complete & STW_result_out)`. A PE that never completed is therefore faulty. Then increment idx; if idx was the last vector go to DONE, else go to LOAD.
- DONE (one cycle): assert `test_done`, then go to IDLE. `fault_map` holds until the next run starts.
- `test_req` outside IDLE is ignored; there is no queuing.
- Arithmetic in the vectors is modulo 2^WORD_SIZE: expected = (op1*op2 + add) truncated.
- Reset at any point, including mid-run: return to IDLE with every output 0 and `fault_map`=0. PEs are not re-initialised by this block.

## Timing
- Reset values: `test_busy`=0, `test_done`=0, `fault_map`=0, `STW_test_load_en`=0, `STW_start`=0, all op buses 0.
- Request to first `STW_test_load_en`: 1 cycle (`test_req` high in cycle n, LOAD in n+1).
- Per vector: 1 (LOAD) + 1 (START) + GUARD_CYCLES + W + 1 (SAMPLE), where W is 1..TIMEOUT_CYCLES.
- If all PEs are already complete on the first WAIT cycle, then W=1.
- `test_done` is asserted in the cycle after the final SAMPLE. `test_busy` drops in the cycle after `test_done`.
- Timeout and all-complete in the same cycle: treated as all-complete; the results are sampled normally.

## Structure
- Package `stw_pkg`: the state enum and `STW_NUM_VECTORS`=4.
- `stw_pkg` also holds the vector constants as {op1, op2, add, expected}:
  - V0 = {3, 5, 7, 22}
  - V1 = {0xFFFF, 1, 1, 0x0000}
  - V2 = {0x00FF, 0x0100, 0, 0xFF00}
  - V3 = {0x8000, 2, 0x1234, 0x1234}
- One sub-module, `stw_vector_rom`: combinational idx → vector lookup from the package constants, registered into the op-bus flops in LOAD.
- FSM, guard/timeout counter and fault-map accumulation live in the top module.

## Test plan
- All PEs healthy (model completes 3 cycles after start, result=1) → 4 load/start pairs, `test_done` pulse, `fault_map`=0.
- PE 5 returns result=0 on V1 only → `fault_map`=0x0020 after done; the bit stays set through V2 and V3.
- PE 0 never completes → each vector exits WAIT after exactly 64 cycles, `fault_map` bit 0 = 1, run still finishes all 4 vectors.
- Stale complete=1 held from reset on all PEs with result=0 → the GUARD window must not sample early, and the final map reflects only post-start results.
- `test_req` pulsed during WAIT → ignored, no second run. `test_req` held high after DONE → a new run starts and `fault_map` clears first.
- `rst` asserted low during WAIT of V2 → all outputs 0 immediately, state IDLE. A new `test_req` restarts from V0.
